// File: rtl/apb_slave_regs_pkg.sv
// Shared definitions for the APB3 register-file completer: register offsets,
// FSM states, register-select encoding and reset constants.
package apb_slave_regs_pkg;

    localparam logic [7:0] CTRL_OFF   = 8'h00;
    localparam logic [7:0] STATUS_OFF = 8'h04;
    localparam logic [7:0] WCNT_OFF   = 8'h08;
    localparam logic [7:0] ID_OFF     = 8'h0C;
    localparam logic [7:0] DATA0_OFF  = 8'h10;
    localparam logic [7:0] DATA1_OFF  = 8'h14;
    localparam logic [7:0] DATA2_OFF  = 8'h18;
    localparam logic [7:0] DATA3_OFF  = 8'h1C;

    localparam int NUM_REGS = 8;

    localparam logic [3:0] CTRL_SPARE_RST = 4'h0;
    localparam logic       STATUS_RST     = 1'b0;

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    // Encoding matches offset[4:2], so the one-hot select bit is sel[offset[4:2]].
    typedef enum logic [2:0] {
        SEL_CTRL,
        SEL_STATUS,
        SEL_WCNT,
        SEL_ID,
        SEL_DATA0,
        SEL_DATA1,
        SEL_DATA2,
        SEL_DATA3
    } reg_sel_t;

    function automatic logic [7:0] ctrl_reset_value(input logic [3:0] ws);
        return {CTRL_SPARE_RST, ws};
    endfunction

endpackage

// File: rtl/apb_regs_decode.sv
// Combinational decode of a latched register offset into a one-hot select,
// plus the address and read-only-write error flags.
module apb_regs_decode
    import apb_slave_regs_pkg::*;
(
    input  logic [7:0]          offset,
    input  logic                write,
    output logic [NUM_REGS-1:0] sel,
    output logic                rd_only,
    output logic                addr_err
);

    always_comb begin
        // NOTE: every output gets a default before any branch, so no path can leave one unassigned and infer a latch.
        sel      = '0;
        rd_only  = 1'b0;
        addr_err = 1'b0;
        if ((offset[1:0] != 2'b00) || (offset > DATA3_OFF)) begin
            addr_err = 1'b1;
        end else begin
            sel[offset[4:2]] = 1'b1;
            rd_only = write && ((offset == WCNT_OFF) || (offset == ID_OFF));
        end
    end

endmodule

// File: rtl/apb_slave_regs.sv
// APB3 completer terminating transfers into a small register file with a
// programmable wait-state count and PSLVERR on bad accesses.
module apb_slave_regs
    import apb_slave_regs_pkg::*;
#(
    parameter int          ADDR_W   = 32,
    parameter int          DATA_W   = 32,
    parameter logic [3:0]  DEF_WAIT = 4'd1,
    parameter logic [31:0] ID_VALUE = 32'hA9B0_0001
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic              proto_err
);

    state_t state, state_nxt;

    logic [7:0]        req_off;
    logic              req_write;
    logic [DATA_W-1:0] req_wdata;
    logic [3:0]        wcnt;

    logic [7:0]        ctrl;
    logic              status_proto;
    logic [15:0]       wr_count;
    logic [DATA_W-1:0] data_q [4];

    logic [NUM_REGS-1:0] sel;
    logic                rd_only;
    logic                addr_err;
    logic                acc_err;

    logic              latch_req;
    logic              wcnt_dec;
    logic              commit;
    logic              proto_set;
    logic              ready;
    logic [DATA_W-1:0] rdata;

    // The interconnect decodes PSEL, so the upper address bits carry no information here.
    logic unused_paddr_hi;
    assign unused_paddr_hi = ^PADDR[ADDR_W-1:8];

    apb_regs_decode u_decode (
        .offset   (req_off),
        .write    (req_write),
        .sel      (sel),
        .rd_only  (rd_only),
        .addr_err (addr_err)
    );

    assign acc_err = addr_err | rd_only;

    always_ff @(posedge PCLK or posedge PRESET) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of block order.
        if (PRESET) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        latch_req = 1'b0;
        wcnt_dec  = 1'b0;
        commit    = 1'b0;
        proto_set = 1'b0;
        ready     = 1'b0;
        case (state)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    latch_req = 1'b1;
                    state_nxt = ACCESS;
                end else if (PSEL && PENABLE) begin
                    proto_set = 1'b1;
                end
            end
            ACCESS: begin
                if (PSEL && PENABLE) begin
                    if (wcnt == 4'd0) begin
                        ready     = 1'b1;
                        commit    = req_write && !acc_err;
                        state_nxt = IDLE;
                    end else begin
                        wcnt_dec = 1'b1;
                    end
                end else begin
                    // Requester abandoned the access phase: flag it and drop the request.
                    proto_set = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            req_off   <= 8'h00;
            req_write <= 1'b0;
            req_wdata <= '0;
            wcnt      <= 4'd0;
        end else if (latch_req) begin
            req_off   <= PADDR[7:0];
            req_write <= PWRITE;
            req_wdata <= PWDATA;
            wcnt      <= ctrl[3:0];
        end else if (wcnt_dec) begin
            wcnt <= wcnt - 4'd1;
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            ctrl     <= ctrl_reset_value(DEF_WAIT);
            wr_count <= 16'h0000;
            // NOTE: the DATA registers are individual flops with a defined reset value, not a RAM, so clearing them here is intended.
            for (int i = 0; i < 4; i++) data_q[i] <= '0;
        end else if (commit) begin
            if (sel[SEL_CTRL])  ctrl      <= req_wdata[7:0];
            if (sel[SEL_DATA0]) data_q[0] <= req_wdata;
            if (sel[SEL_DATA1]) data_q[1] <= req_wdata;
            if (sel[SEL_DATA2]) data_q[2] <= req_wdata;
            if (sel[SEL_DATA3]) data_q[3] <= req_wdata;
            wr_count <= wr_count + 16'd1;
        end
    end

    // Set has priority over the write-1-to-clear.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET)
            status_proto <= STATUS_RST;
        else if (proto_set)
            status_proto <= 1'b1;
        else if (commit && sel[SEL_STATUS] && req_wdata[0])
            status_proto <= 1'b0;
    end

    always_comb begin
        rdata = '0;
        if (sel[SEL_CTRL])   rdata = {{(DATA_W-8){1'b0}}, ctrl};
        if (sel[SEL_STATUS]) rdata = {{(DATA_W-1){1'b0}}, status_proto};
        if (sel[SEL_WCNT])   rdata = {{(DATA_W-16){1'b0}}, wr_count};
        if (sel[SEL_ID])     rdata = ID_VALUE;
        if (sel[SEL_DATA0])  rdata = data_q[0];
        if (sel[SEL_DATA1])  rdata = data_q[1];
        if (sel[SEL_DATA2])  rdata = data_q[2];
        if (sel[SEL_DATA3])  rdata = data_q[3];
    end

    assign PREADY    = ready;
    assign PSLVERR   = ready && acc_err;
    assign PRDATA    = (ready && !acc_err && !req_write) ? rdata : '0;
    assign proto_err = status_proto;

endmodule

// File: tb/tb_apb_slave_regs.sv
// Self-checking bench for apb_slave_regs: directed vector table, abort and
// reset sequences, and randomized traffic against a register-level model.
module tb_apb_slave_regs;

    localparam logic [31:0] ID_VALUE = 32'hA9B0_0001;
    localparam logic [3:0]  DEF_WAIT = 4'd1;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic        PREADY, PSLVERR, proto_err;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state, kept at register granularity.
    logic [7:0]  m_ctrl;
    logic        m_status;
    logic [15:0] m_wcnt;
    logic [31:0] m_data [4];

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_waits;
    } vec_t;

    vec_t vecs [20];

    apb_slave_regs #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .DEF_WAIT (DEF_WAIT),
        .ID_VALUE (ID_VALUE)
    ) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR),
        .proto_err (proto_err)
    );

    always #5 PCLK = ~PCLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic model_reset();
        m_ctrl   = {4'h0, DEF_WAIT};
        m_status = 1'b0;
        m_wcnt   = 16'h0;
        for (int i = 0; i < 4; i++) m_data[i] = 32'h0;
    endtask

    // Expected outcome of one completed transfer, then apply its effect.
    task automatic model_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                              output logic [31:0] exp_rdata, output logic exp_err, output int exp_waits);
        int off;
        off       = int'(addr[7:0]);
        exp_waits = int'(m_ctrl[3:0]);
        exp_rdata = 32'h0;
        exp_err   = (off % 4 != 0) || (off > 28) || (wr && (off == 8 || off == 12));
        if (!exp_err) begin
            if (wr) begin
                if (off == 0)       m_ctrl = wdata[7:0];
                else if (off == 4)  begin if (wdata[0]) m_status = 1'b0; end
                else if (off >= 16) m_data[off/4 - 4] = wdata;
                m_wcnt = m_wcnt + 16'd1;
            end else begin
                case (off)
                    0:       exp_rdata = {24'h0, m_ctrl};
                    4:       exp_rdata = {31'h0, m_status};
                    8:       exp_rdata = {16'h0, m_wcnt};
                    12:      exp_rdata = ID_VALUE;
                    default: exp_rdata = m_data[off/4 - 4];
                endcase
            end
        end
    endtask

    // Starts just after a rising edge; returns just after the completing edge with the bus idle.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int waits);
        int leaks;
        bit done;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
        @(negedge PCLK);
        leaks = (PREADY || PSLVERR || PRDATA != 32'h0) ? 1 : 0;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        waits = 0; done = 1'b0; rdata = 32'h0; err = 1'b0;
        while (!done && waits < 40) begin
            @(negedge PCLK);
            if (PREADY) begin
                rdata = PRDATA; err = PSLVERR; done = 1'b1;
            end else begin
                if (PSLVERR || PRDATA != 32'h0) leaks++;
                waits++;
            end
        end
        check("pready_timeout", {31'h0, done}, 32'h1);
        check("outputs_quiet_while_not_ready", leaks, 0);
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic mxfer(input string name, input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] e_rd, rd;
        logic        e_err, err;
        int          e_w, w;
        model_xfer(wr, addr, wdata, e_rd, e_err, e_w);
        xfer(wr, addr, wdata, rd, err, w);
        check({name, "_prdata"}, rd, e_rd);
        check({name, "_pslverr"}, {31'h0, err}, {31'h0, e_err});
        check({name, "_waits"}, w, e_w);
    endtask

    // PSEL and PENABLE high together while idle: a protocol violation with no register effect.
    task automatic bogus_access(input logic [31:0] wdata);
        PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 32'h10; PWDATA = wdata;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        m_status = 1'b1;
    endtask

    initial begin
        logic [31:0] rd, e_rd, addr, wdata;
        logic        err, e_err, wr;
        int          w, e_w, r;

        vecs[0]  = '{1'b0, 32'h0000_000C, 32'h0,         ID_VALUE,      1'b0, 1};
        vecs[1]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         1'b0, 1};
        vecs[2]  = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0, 1};
        vecs[3]  = '{1'b0, 32'h0000_0008, 32'h0,         32'h1,         1'b0, 1};
        vecs[4]  = '{1'b1, 32'h0000_0000, 32'h0,         32'h0,         1'b0, 1};
        vecs[5]  = '{1'b1, 32'h0000_0014, 32'h1111_1111, 32'h0,         1'b0, 0};
        vecs[6]  = '{1'b1, 32'h0000_0018, 32'h2222_2222, 32'h0,         1'b0, 0};
        vecs[7]  = '{1'b1, 32'h0000_0000, 32'h3,         32'h0,         1'b0, 0};
        vecs[8]  = '{1'b0, 32'h0000_0018, 32'h0,         32'h2222_2222, 1'b0, 3};
        vecs[9]  = '{1'b1, 32'h0000_0008, 32'h5,         32'h0,         1'b1, 3};
        vecs[10] = '{1'b1, 32'h0000_0022, 32'h7777_7777, 32'h0,         1'b1, 3};
        vecs[11] = '{1'b0, 32'h0000_0040, 32'h0,         32'h0,         1'b1, 3};
        vecs[12] = '{1'b0, 32'h0000_0008, 32'h0,         32'h5,         1'b0, 3};
        vecs[13] = '{1'b0, 32'h0000_0014, 32'h0,         32'h1111_1111, 1'b0, 3};
        vecs[14] = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0, 3};
        vecs[15] = '{1'b1, 32'h0000_0000, 32'hFFFF_FFA3, 32'h0,         1'b0, 3};
        vecs[16] = '{1'b0, 32'h0000_0000, 32'h0,         32'h0000_00A3, 1'b0, 3};
        vecs[17] = '{1'b0, 32'hFFFF_FF0C, 32'h0,         ID_VALUE,      1'b0, 3};
        vecs[18] = '{1'b0, 32'h0000_0004, 32'h0,         32'h0,         1'b0, 3};
        vecs[19] = '{1'b0, 32'h0000_001C, 32'h0,         32'h0,         1'b0, 3};

        PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'h0; PWDATA = 32'h0;
        model_reset();
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        check("reset_pready", {31'h0, PREADY}, 32'h0);
        check("reset_pslverr", {31'h0, PSLVERR}, 32'h0);
        check("reset_prdata", PRDATA, 32'h0);
        check("reset_proto_err", {31'h0, proto_err}, 32'h0);
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        @(posedge PCLK); #1;

        // Table vectors run back to back with no idle cycle between them.
        for (int i = 0; i < 20; i++) begin
            model_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, e_rd, e_err, e_w);
            xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, err, w);
            check($sformatf("vec%0d_prdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d_pslverr", i), {31'h0, err}, {31'h0, vecs[i].exp_err});
            check($sformatf("vec%0d_waits", i), w, vecs[i].exp_waits);
        end

        // Write to DATA3 abandoned after one wait cycle.
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h1C; PWDATA = 32'h1234;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        m_status = 1'b1;
        check("abort_proto_err", {31'h0, proto_err}, 32'h1);
        xfer(1'b0, 32'h1C, 32'h0, rd, err, w);
        check("abort_data3_kept", rd, 32'h0);
        xfer(1'b0, 32'h04, 32'h0, rd, err, w);
        check("abort_status_read", rd, 32'h1);
        xfer(1'b0, 32'h04, 32'h0, rd, err, w);
        check("status_not_clear_on_read", rd, 32'h1);
        xfer(1'b1, 32'h04, 32'h1, rd, err, w);
        m_status = 1'b0;
        m_wcnt   = m_wcnt + 16'd1;
        @(negedge PCLK);
        check("w1c_proto_err", {31'h0, proto_err}, 32'h0);
        @(posedge PCLK); #1;

        bogus_access(32'hBAD0_BAD0);
        @(negedge PCLK);
        check("idle_access_proto_err", {31'h0, proto_err}, 32'h1);
        @(posedge PCLK); #1;
        mxfer("idle_access_data0", 1'b0, 32'h10, 32'h0);

        for (int n = 0; n < 150; n++) begin
            r     = int'($urandom_range(0, 15));
            wr    = 1'($urandom_range(0, 1));
            wdata = $urandom();
            if (r < 12)       addr = {$urandom_range(0, 7), 2'b00};
            else if (r == 12) addr = {$urandom_range(0, 7), 2'b00} + 32'($urandom_range(1, 3));
            else if (r == 13) addr = {$urandom() & 32'hFFFF_FF00} | 32'($urandom_range(32, 255));
            else              addr = {$urandom() & 32'hFFFF_FF00} | {$urandom_range(0, 7), 2'b00};
            if (r == 15) begin
                bogus_access(wdata);
            end else begin
                mxfer($sformatf("rnd%0d", n), wr, addr, wdata);
            end
            if (n % 10 == 0) begin
                @(negedge PCLK);
                check($sformatf("rnd%0d_proto_err", n), {31'h0, proto_err}, {31'h0, m_status});
                @(posedge PCLK); #1;
            end
        end

        // Reset during the wait cycles of a DATA0 write.
        mxfer("pre_reset_ctrl", 1'b1, 32'h00, 32'h3);
        mxfer("pre_reset_data0", 1'b1, 32'h10, 32'h5555_AAAA);
        bogus_access(32'h0);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h10; PWDATA = 32'hCAFE_F00D;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        PRESET = 1'b1;
        #1;
        check("midreset_pready", {31'h0, PREADY}, 32'h0);
        check("midreset_pslverr", {31'h0, PSLVERR}, 32'h0);
        check("midreset_prdata", PRDATA, 32'h0);
        check("midreset_proto_err", {31'h0, proto_err}, 32'h0);
        PSEL = 1'b0; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        model_reset();
        @(posedge PCLK); #1;
        xfer(1'b0, 32'h10, 32'h0, rd, err, w);
        check("postreset_data0", rd, 32'h0);
        xfer(1'b0, 32'h00, 32'h0, rd, err, w);
        check("postreset_ctrl", rd, {28'h0, DEF_WAIT});
        check("postreset_waits", w, int'(DEF_WAIT));
        mxfer("postreset_wcnt", 1'b0, 32'h08, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
